dispense_sequencer: RTL and testbench

//  Multi-channel successor to the single-tray candy dispense logic. Accepts a dispense command (channel, amount,

---
 rtl/dispense_sequencer_if.sv | 29 ++
 rtl/dispense_sequencer.sv | 151 +++++++++++++++
 tb/tb_dispense_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dispense_sequencer_if.sv
// Host command/status bundle for dispense_sequencer: command handshake plus
// run status pulses. The host side drives commands, the sequencer reports back.
interface dispense_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int AMT_W  = 2
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cmd_valid;
  logic [CH_W-1:0]  cmd_chan;
  logic [AMT_W-1:0] cmd_amount;
  logic             cmd_dir;
  logic             abort;
  logic             cmd_ack;
  logic             cmd_err;
  logic             busy;
  logic             done;
  logic             aborted;

  modport master (
    output cmd_valid, cmd_chan, cmd_amount, cmd_dir, abort,
    input  cmd_ack, cmd_err, busy, done, aborted
  );

  modport slave (
    input  cmd_valid, cmd_chan, cmd_amount, cmd_dir, abort,
    output cmd_ack, cmd_err, busy, done, aborted
  );
endinterface

// File: rtl/dispense_sequencer.sv
// Multi-channel dispense sequencer: accepts a host command, runs one stepper
// channel for amount*STEPS_PER_UNIT steps, then holds the servo gate open.
module dispense_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int AMT_W          = 2,
  parameter int STEPS_PER_UNIT = 200,
  parameter int STEP_DIV       = 6000,
  parameter int DIR_SETUP      = 120,
  parameter int GATE_CYC       = 6000000,
  parameter int SERVO_PERIOD   = 240000,
  parameter int SERVO_OPEN     = 24000,
  parameter int SERVO_CLOSE    = 12000
) (
  input  logic                 clk_x1,
  input  logic                 rstn,
  dispense_sequencer_if.slave  host,
  output logic [NUM_CH-1:0]    step,
  output logic [NUM_CH-1:0]    dir,
  output logic                 servo_pwm
);
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TGT_MAX = ((1 << AMT_W) - 1) * STEPS_PER_UNIT;
  localparam int TGT_W   = $clog2(TGT_MAX + 1);
  localparam int CNT_MX1 = (DIR_SETUP > STEP_DIV) ? DIR_SETUP : STEP_DIV;
  localparam int CNT_MAX = (CNT_MX1 > GATE_CYC) ? CNT_MX1 : GATE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PWM_W   = $clog2(SERVO_PERIOD + 1);
  localparam int HALF    = STEP_DIV / 2;

  typedef enum logic [1:0] {S_IDLE, S_DIR_SET, S_STEP, S_GATE} state_t;

  state_t           r_state, w_next;
  logic [CH_W-1:0]  r_chan;
  logic [AMT_W-1:0] r_amount;
  logic [TGT_W-1:0] r_steps, w_target;
  logic [CNT_W-1:0] r_cnt;
  logic [NUM_CH-1:0] r_dir;
  logic             r_ack, r_err, r_done, r_aborted;
  logic [PWM_W-1:0] r_width, r_active, r_pwm_cnt;
  logic [31:0]      w_chan_ext;
  logic             w_chan_bad, w_amt_zero, w_dir_end, w_half_end, w_period_end;
  logic             w_gate_end, w_last_step;

  assign w_chan_ext   = 32'(host.cmd_chan);
  assign w_chan_bad   = (w_chan_ext >= 32'(NUM_CH));
  assign w_amt_zero   = (host.cmd_amount == '0);
  assign w_target     = TGT_W'(r_amount) * TGT_W'(STEPS_PER_UNIT);
  assign w_dir_end    = (r_cnt == CNT_W'(DIR_SETUP - 1));
  assign w_half_end   = (r_cnt == CNT_W'(HALF - 1));
  assign w_period_end = (r_cnt == CNT_W'(STEP_DIV - 1));
  assign w_gate_end   = (r_cnt == CNT_W'(GATE_CYC - 1));
  assign w_last_step  = (r_steps == w_target);

  always_ff @(posedge clk_x1 or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (host.cmd_valid && !w_chan_bad && !w_amt_zero) w_next = S_DIR_SET;
      S_DIR_SET: if (host.abort) w_next = S_IDLE;
                 else if (w_dir_end) w_next = S_STEP;
      S_STEP:    if (host.abort) w_next = S_IDLE;
                 else if (w_period_end && w_last_step) w_next = S_GATE;
      S_GATE:    if (host.abort || w_gate_end) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    step      = '0;
    host.busy = (r_state != S_IDLE);
    if (r_state == S_STEP && r_cnt < CNT_W'(HALF)) begin
      for (int unsigned i = 0; i < NUM_CH; i++) step[i] = (r_chan == CH_W'(i));
    end
  end

  always_ff @(posedge clk_x1 or negedge rstn) begin
    if (!rstn) begin
      r_chan    <= '0;
      r_amount  <= '0;
      r_steps   <= '0;
      r_cnt     <= '0;
      r_dir     <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_width   <= PWM_W'(SERVO_CLOSE);
      r_active  <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      // Active width only reloads at the period wrap so pulses are never cut short.
      if (r_pwm_cnt == PWM_W'(SERVO_PERIOD - 1)) begin
        r_pwm_cnt <= '0;
        r_active  <= r_width;
      end else begin
        r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      end
      case (r_state)
        S_IDLE: if (host.cmd_valid) begin
          if (w_chan_bad) r_err <= 1'b1;
          else begin
            r_ack <= 1'b1;
            if (w_amt_zero) r_done <= 1'b1;
            else begin
              r_chan   <= host.cmd_chan;
              r_amount <= host.cmd_amount;
              r_cnt    <= '0;
              r_steps  <= '0;
              for (int unsigned i = 0; i < NUM_CH; i++)
                if (host.cmd_chan == CH_W'(i)) r_dir[i] <= host.cmd_dir;
            end
          end
        end
        S_DIR_SET: r_cnt <= w_dir_end ? '0 : r_cnt + CNT_W'(1);
        S_STEP: begin
          r_cnt <= w_period_end ? '0 : r_cnt + CNT_W'(1);
          if (w_half_end) r_steps <= r_steps + TGT_W'(1);
          if (w_period_end && w_last_step) r_width <= PWM_W'(SERVO_OPEN);
        end
        S_GATE: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_gate_end) begin
            r_width <= PWM_W'(SERVO_CLOSE);
            r_done  <= 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
      if (r_state != S_IDLE && host.abort) begin
        r_aborted <= 1'b1;
        r_done    <= 1'b0;
        r_width   <= PWM_W'(SERVO_CLOSE);
      end
    end
  end

  assign host.cmd_ack = r_ack;
  assign host.cmd_err = r_err;
  assign host.done    = r_done;
  assign host.aborted = r_aborted;
  assign dir          = r_dir;
  assign servo_pwm    = (r_pwm_cnt < r_active);
endmodule

// File: tb/tb_dispense_sequencer.sv
// Randomized bench for dispense_sequencer: expected timing, pulse counts, dir
// and servo waveform are derived from the command rules with plain arithmetic.
module tb_dispense_sequencer;
  localparam int SPU = 4, SD = 4, DS = 2, G = 8, PER = 40, OPEN = 4, CLOSE = 2;

  logic clk_x1 = 1'b0;
  logic rstn   = 1'b1;
  always #5 clk_x1 = ~clk_x1;

  dispense_sequencer_if #(.NUM_CH(4), .AMT_W(2)) bus ();
  dispense_sequencer_if #(.NUM_CH(3), .AMT_W(2)) bus3 ();
  logic [3:0] step, dir;
  logic       servo_pwm;
  logic [2:0] step3, dir3;
  logic       servo3;

  dispense_sequencer #(
    .NUM_CH(4), .AMT_W(2), .STEPS_PER_UNIT(SPU), .STEP_DIV(SD), .DIR_SETUP(DS),
    .GATE_CYC(G), .SERVO_PERIOD(PER), .SERVO_OPEN(OPEN), .SERVO_CLOSE(CLOSE)
  ) dut (
    .clk_x1(clk_x1), .rstn(rstn), .host(bus), .step(step), .dir(dir), .servo_pwm(servo_pwm)
  );

  dispense_sequencer #(
    .NUM_CH(3), .AMT_W(2), .STEPS_PER_UNIT(SPU), .STEP_DIV(SD), .DIR_SETUP(DS),
    .GATE_CYC(G), .SERVO_PERIOD(PER), .SERVO_OPEN(OPEN), .SERVO_CLOSE(CLOSE)
  ) dut3 (
    .clk_x1(clk_x1), .rstn(rstn), .host(bus3), .step(step3), .dir(dir3), .servo_pwm(servo3)
  );

  int         n_pass = 0, n_total = 0;
  int         cyc = 0;
  int         m_active = 0, m_wprev = CLOSE;
  bit         exp_pwm;
  logic [3:0] model_dir = '0;

  // One clock: advance to the next negedge and update the servo model with the
  // gate width the sequencer should be holding during that cycle.
  task automatic tick(input int w_now);
    @(negedge clk_x1);
    cyc++;
    if (cyc % PER == 0) m_active = m_wprev;
    m_wprev = w_now;
    exp_pwm = ((cyc % PER) < m_active);
  endtask

  task automatic restart_model();
    cyc = 0; m_active = 0; m_wprev = CLOSE; model_dir = '0;
  endtask

  task automatic align(input int m);
    for (int k = 0; k < PER && (cyc % PER) != m; k++) tick(CLOSE);
  endtask

  task automatic test_reset();
    logic [12:0] v;
    bus.cmd_valid = 0; bus.cmd_chan = 0; bus.cmd_amount = 0; bus.cmd_dir = 0; bus.abort = 0;
    bus3.cmd_valid = 0; bus3.cmd_chan = 0; bus3.cmd_amount = 0; bus3.cmd_dir = 0; bus3.abort = 0;
    #1 rstn = 1'b0;
    #1;
    v = {bus.cmd_ack, bus.cmd_err, bus.busy, bus.done, bus.aborted, step, dir, servo_pwm};
    n_total++;
    if (v !== '0) $display("FAIL reset_outputs: got %b, required all 0", v); else n_pass++;
    @(negedge clk_x1);
    rstn = 1'b1;
    restart_model();
  endtask

  task automatic test_idle_servo();
    int bad = 0, act = 0;
    for (int i = 0; i < 2 * PER + 5; i++) begin
      tick(CLOSE);
      if (servo_pwm !== exp_pwm) bad++;
      if (bus.busy || step != 0 || bus.done || bus.cmd_ack) act++;
    end
    n_total++;
    if (bad != 0) $display("FAIL idle_servo: %0d cycles differ from closed-gate waveform, required 0", bad); else n_pass++;
    n_total++;
    if (act != 0) $display("FAIL idle_quiet: %0d active cycles, required 0", act); else n_pass++;
  endtask

  task automatic test_abort_idle();
    int hits = 0;
    bus.abort = 1;
    for (int i = 0; i < 10; i++) begin
      tick(CLOSE);
      if (bus.aborted || bus.busy || step != 0) hits++;
    end
    bus.abort = 0;
    n_total++;
    if (hits != 0) $display("FAIL abort_idle: %0d cycles reacted, required 0", hits); else n_pass++;
  endtask

  task automatic run_cmd(input string nm, input int ch, input int amt, input bit d,
                         input int abort_at, input int extra_at, input bit abort_with_cmd);
    int n_steps, t_total, win, gate_lo;
    int acks = 0, ack_cyc = -1, errs = 0, busy_n = 0, dones = 0, done_cyc = -1, aborts = 0;
    int rises = 0, first_rise = -1, hi_len = 0, hi_bad = 0, other_bad = 0, srv_bad = 0, abort_cyc = -1;
    int exp_rises;
    bit prev_s = 0, s, abort_sent = 0, after_ok = 0;
    logic [3:0] exp_dir, dir0, mask;
    n_steps = amt * SPU;
    t_total = (amt == 0) ? 0 : DS + n_steps * SD + G;
    gate_lo = DS + n_steps * SD;
    win     = t_total + 45;
    exp_dir = model_dir;
    if (amt > 0) exp_dir[ch] = d;
    mask = 4'b0001 << ch;
    bus.cmd_chan = ch[1:0]; bus.cmd_amount = amt[1:0]; bus.cmd_dir = d;
    bus.cmd_valid = 1; bus.abort = abort_with_cmd;
    for (int i = 0; i < win; i++) begin
      tick((abort_at < 0 && amt > 0 && i >= gate_lo && i < t_total) ? OPEN : CLOSE);
      bus.cmd_valid = 0; bus.abort = 0;
      if (i == 0) dir0 = dir;
      if (bus.cmd_ack) begin acks++; if (ack_cyc < 0) ack_cyc = i; end
      if (bus.cmd_err) errs++;
      if (bus.busy) busy_n++;
      if (bus.done) begin dones++; if (done_cyc < 0) done_cyc = i; end
      if (bus.aborted) aborts++;
      if (servo_pwm !== exp_pwm) srv_bad++;
      if ((step & ~mask) != 4'b0000) other_bad++;
      s = step[ch];
      if (abort_sent && i == abort_cyc + 1) after_ok = (step == 4'b0000 && bus.aborted && !bus.busy);
      if (s && !prev_s) begin rises++; hi_len = 1; if (first_rise < 0) first_rise = i; end
      else if (s) hi_len++;
      else if (prev_s && !abort_sent && hi_len != SD / 2) hi_bad++;
      prev_s = s;
      if (abort_at > 0 && !abort_sent && s && hi_len == 1 && rises == abort_at) begin
        bus.abort = 1; abort_sent = 1; abort_cyc = i;
      end
      if (extra_at >= 0 && i == extra_at) begin
        bus.cmd_chan = 2'($urandom_range(0, 3)); bus.cmd_amount = 2'd1; bus.cmd_valid = 1;
      end
    end
    exp_rises = (abort_at > 0) ? abort_at : n_steps;
    n_total++;
    if (acks != 1 || ack_cyc != 0) $display("FAIL %s ack: got %0d acks first at cycle %0d, required 1 at cycle 0", nm, acks, ack_cyc); else n_pass++;
    n_total++;
    if (errs != 0) $display("FAIL %s err: got %0d err pulses, required 0", nm, errs); else n_pass++;
    n_total++;
    if (dir0 !== exp_dir) $display("FAIL %s dir_at_ack: got %b, required %b", nm, dir0, exp_dir); else n_pass++;
    n_total++;
    if (rises != exp_rises) $display("FAIL %s step_count: got %0d pulses, required %0d", nm, rises, exp_rises); else n_pass++;
    n_total++;
    if (other_bad != 0) $display("FAIL %s other_channels: %0d cycles with foreign step bits, required 0", nm, other_bad); else n_pass++;
    n_total++;
    if (hi_bad != 0) $display("FAIL %s step_width: %0d pulses not %0d cycles high", nm, hi_bad, SD / 2); else n_pass++;
    if (n_steps > 0) begin
      n_total++;
      if (first_rise != DS) $display("FAIL %s first_step: got cycle %0d, required %0d", nm, first_rise, DS); else n_pass++;
    end
    n_total++;
    if (dones != ((abort_at > 0) ? 0 : 1)) $display("FAIL %s done_count: got %0d, required %0d", nm, dones, (abort_at > 0) ? 0 : 1); else n_pass++;
    n_total++;
    if (aborts != ((abort_at > 0) ? 1 : 0)) $display("FAIL %s aborted_count: got %0d, required %0d", nm, aborts, (abort_at > 0) ? 1 : 0); else n_pass++;
    if (abort_at <= 0) begin
      n_total++;
      if (done_cyc != t_total || busy_n != t_total)
        $display("FAIL %s timing: done at %0d busy %0d cycles, required %0d and %0d", nm, done_cyc, busy_n, t_total, t_total);
      else n_pass++;
    end else begin
      n_total++;
      if (!after_ok) $display("FAIL %s abort_response: got sent=%0d ok=%0d, required step 0, aborted 1, busy 0", nm, abort_sent, after_ok); else n_pass++;
    end
    n_total++;
    if (srv_bad != 0) $display("FAIL %s servo: %0d cycles differ from expected waveform, required 0", nm, srv_bad); else n_pass++;
    n_total++;
    if (dir !== exp_dir) $display("FAIL %s dir_final: got %b, required %b", nm, dir, exp_dir); else n_pass++;
    model_dir = exp_dir;
  endtask

  task automatic test_bad_chan();
    int extra = 0;
    bus3.cmd_chan = 2'd3; bus3.cmd_amount = 2'd2; bus3.cmd_dir = 1; bus3.cmd_valid = 1;
    tick(CLOSE);
    bus3.cmd_valid = 0;
    n_total++;
    if (bus3.cmd_err !== 1'b1 || bus3.cmd_ack !== 1'b0 || bus3.busy !== 1'b0)
      $display("FAIL bad_chan: got err=%b ack=%b busy=%b, required err=1 ack=0 busy=0", bus3.cmd_err, bus3.cmd_ack, bus3.busy);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      tick(CLOSE);
      if (bus3.cmd_ack || bus3.cmd_err || bus3.busy || step3 != 0) extra++;
    end
    n_total++;
    if (extra != 0) $display("FAIL bad_chan_after: %0d active cycles, required 0", extra); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [12:0] v;
    bus.cmd_chan = 2'd1; bus.cmd_amount = 2'd2; bus.cmd_dir = 1; bus.cmd_valid = 1;
    tick(CLOSE);
    bus.cmd_valid = 0;
    for (int i = 1; i <= DS + 4; i++) tick(CLOSE);
    n_total++;
    if (step !== 4'b0010) $display("FAIL mid_step_pre: got step %b, required 0010", step); else n_pass++;
    rstn = 1'b0;
    #1;
    v = {bus.cmd_ack, bus.cmd_err, bus.busy, bus.done, bus.aborted, step, dir, servo_pwm};
    n_total++;
    if (v !== '0) $display("FAIL mid_step_reset: got %b, required all 0", v); else n_pass++;
    @(negedge clk_x1);
    rstn = 1'b1;
    restart_model();
  endtask

  initial begin
    int ch, amt;
    bit d;
    test_reset();
    test_idle_servo();
    test_abort_idle();
    align(27);
    run_cmd("dispense_basic", 2, 3, 1'b1, -1, -1, 1'b0);
    run_cmd("zero_amount", 1, 0, 1'b1, -1, -1, 1'b0);
    test_bad_chan();
    run_cmd("abort", 1, 3, 1'b1, 6, -1, 1'b0);
    run_cmd("back_to_back", 0, 3, 1'b1, -1, 10, 1'b0);
    for (int k = 0; k < 4; k++) begin
      ch  = $urandom_range(0, 3);
      amt = $urandom_range(1, 3);
      d   = 1'($urandom_range(0, 1));
      align($urandom_range(0, PER - 1));
      run_cmd("random", ch, amt, d, -1, -1, k == 3);
    end
    test_reset_mid();
    test_idle_servo();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end
endmodule
